// File: rtl/rgb_fader_pkg.sv
// Shared types and channel indices for the RGB LED fader.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshakes).
package rgb_fader_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RAMP = 1'b1
   } fader_state_t;

   // Bit positions of each colour in rgb_in / rgb_out.
   localparam int CH_RED   = 2;
   localparam int CH_GREEN = 1;
   localparam int CH_BLUE  = 0;

endpackage

// File: rtl/rgb_fader_pwm_compare.sv
// Per-channel PWM comparator: raw LED level from the shared counter and the channel duty.
// Latency: combinational; the parent registers the result.
// Backpressure: none. RGB_FADER_GAMMA_EN squares the duty before the compare.
module pwm_compare #(
   parameter int PWM_BITS = 8
) (
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic [PWM_BITS-1:0] duty,
   output logic                raw_on
);

   logic [PWM_BITS-1:0] eff;

`ifdef RGB_FADER_GAMMA_EN
   logic [2*PWM_BITS-1:0] duty_sq;

   // Square at double width and keep the top half so the fade looks perceptually linear.
   always_comb begin
      duty_sq = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
      eff     = duty_sq[2*PWM_BITS-1:PWM_BITS];
   end
`else
   // Linear duty: compare the raw value directly.
   always_comb begin
      eff = duty;
   end
`endif

   // Full-scale duty is forced fully on; the gamma curve never reaches MAX_DUTY by itself.
   always_comb begin
      raw_on = (duty == {PWM_BITS{1'b1}}) ? 1'b1 : (pwm_cnt < eff);
   end

endmodule

// File: rtl/rgb_fader.sv
// RGB LED fader: ramps each channel's PWM duty one LSB per STEP_TICKS clocks toward rgb_in.
// Latency: rgb_out is registered (1 clock behind duty/pwm_cnt); busy rises 1 clock after a target mismatch.
// Backpressure: none; rgb_in is sampled every cycle. RGB_FADER_GAMMA_EN selects the gamma-corrected compare.
module rgb_fader
   import rgb_fader_pkg::*;
#(
   parameter int PWM_BITS   = 8,
   parameter int STEP_TICKS = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] rgb_in,
   output logic [2:0] rgb_out,
   output logic       busy
);

   localparam int                  PW        = $clog2(STEP_TICKS + 1);
   localparam logic [PWM_BITS-1:0] MAX_DUTY  = {PWM_BITS{1'b1}};
   localparam logic [PW-1:0]       TICK_LAST = PW'(STEP_TICKS - 1);

   fader_state_t        state_q, state_d;
   logic                busy_q, busy_d;
   logic [2:0]          rgb_out_q, rgb_out_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [PWM_BITS-1:0] duty_q [3];
   logic [PWM_BITS-1:0] duty_d [3];
   logic [PWM_BITS-1:0] target [3];
   logic [2:0]          raw_on;
   logic                idle_match;
   logic                step_match;

   for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      pwm_compare #(.PWM_BITS(PWM_BITS)) u_cmp (
         .pwm_cnt (pwm_cnt_q),
         .duty    (duty_q[ch]),
         .raw_on  (raw_on[ch])
      );
   end

   // Each requested colour bit selects fully off or full scale.
   always_comb begin
      target[CH_RED]   = rgb_in[CH_RED]   ? MAX_DUTY : '0;
      target[CH_GREEN] = rgb_in[CH_GREEN] ? MAX_DUTY : '0;
      target[CH_BLUE]  = rgb_in[CH_BLUE]  ? MAX_DUTY : '0;
   end

   // Next-state: free-running PWM counter, prescaler, lockstep duty steps and idle/ramp control.
   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      duty_d     = duty_q;
      pwm_cnt_d  = pwm_cnt_q + 1'b1;
      rgb_out_d  = raw_on;
      idle_match = 1'b1;
      step_match = 1'b1;

      for (int i = 0; i < 3; i++) begin
         if (duty_q[i] != target[i]) idle_match = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            presc_d = '0;
            if (!idle_match) state_d = S_RAMP;
         end
         S_RAMP: begin
            if (presc_q == TICK_LAST) begin
               presc_d = '0;
               // Step only when strictly below/above target, so duty never wraps.
               for (int i = 0; i < 3; i++) begin
                  if (duty_q[i] < target[i]) begin
                     duty_d[i] = duty_q[i] + 1'b1;
                  end else if (duty_q[i] > target[i]) begin
                     duty_d[i] = duty_q[i] - 1'b1;
                  end
                  if (duty_d[i] != target[i]) step_match = 1'b0;
               end
               if (step_match) state_d = S_IDLE;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RAMP);
   end

   // All state and registered outputs; synchronous reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         rgb_out_q <= '0;
         pwm_cnt_q <= '0;
         presc_q   <= '0;
         for (int i = 0; i < 3; i++) duty_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         rgb_out_q <= rgb_out_d;
         pwm_cnt_q <= pwm_cnt_d;
         presc_q   <= presc_d;
         for (int i = 0; i < 3; i++) duty_q[i] <= duty_d[i];
      end
   end

   assign rgb_out = rgb_out_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_rgb_fader.sv
// Self-checking bench for rgb_fader (PWM_BITS=4, STEP_TICKS=4) plus a slow instance for PWM shape.
// Latency: a cycle model pushes expected outputs at each edge; they are popped 1 time unit later.
// Backpressure: n/a.
module tb_rgb_fader;

   localparam int PB   = 4;
   localparam int ST   = 4;
   localparam int MAXD = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] rgb_in = 3'b111;
   logic [2:0] rgb_out;
   logic       busy;

   logic       rst_s = 1'b1;
   logic [2:0] rgb_in_s = 3'b000;
   logic [2:0] rgb_out_s;
   logic       busy_s;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rgb_fader #(.PWM_BITS(PB), .STEP_TICKS(ST)) dut (
      .clk     (clk),
      .rst     (rst),
      .rgb_in  (rgb_in),
      .rgb_out (rgb_out),
      .busy    (busy)
   );

   rgb_fader #(.PWM_BITS(PB), .STEP_TICKS(32)) dut_s (
      .clk     (clk),
      .rst     (rst_s),
      .rgb_in  (rgb_in_s),
      .rgb_out (rgb_out_s),
      .busy    (busy_s)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int eff_of(input int d);
`ifdef RGB_FADER_GAMMA_EN
      return (d * d) >> PB;
`else
      return d;
`endif
   endfunction

   // ---------------- reference model + scoreboard ----------------
   bit         m_ramp;
   int         m_duty [3];
   int         m_pwm;
   int         m_presc;
   logic [2:0] m_out;
   int         m_tgt;
   bit         m_all;
   logic [15:0] exp_q [$];
   logic [15:0] exp_v;

   always @(posedge clk) begin
      if (rst) begin
         m_ramp = 0; m_pwm = 0; m_presc = 0; m_out = 3'b000;
         for (int i = 0; i < 3; i++) m_duty[i] = 0;
      end else begin
         for (int i = 0; i < 3; i++)
            m_out[i] = (m_duty[i] == MAXD) ? 1'b1 : (m_pwm < eff_of(m_duty[i]));
         m_pwm = (m_pwm + 1) % (MAXD + 1);
         if (!m_ramp) begin
            m_presc = 0;
            for (int i = 0; i < 3; i++) begin
               m_tgt = rgb_in[i] ? MAXD : 0;
               if (m_duty[i] != m_tgt) m_ramp = 1;
            end
         end else if (m_presc == ST - 1) begin
            m_presc = 0;
            m_all   = 1;
            for (int i = 0; i < 3; i++) begin
               m_tgt = rgb_in[i] ? MAXD : 0;
               if (m_duty[i] < m_tgt) m_duty[i]++;
               else if (m_duty[i] > m_tgt) m_duty[i]--;
               if (m_duty[i] != m_tgt) m_all = 0;
            end
            if (m_all) m_ramp = 0;
         end else begin
            m_presc++;
         end
      end
      exp_q.push_back({m_out, m_ramp, 4'(m_duty[2]), 4'(m_duty[1]), 4'(m_duty[0])});
   end

   always @(posedge clk) begin
      #1;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         exp_v = exp_q.pop_front();
         chk("sb_cycle", {16'd0, rgb_out, busy, dut.duty_q[2], dut.duty_q[1], dut.duty_q[0]},
             {16'd0, exp_v});
      end
   end

   // ---------------- directed sequence ----------------
   task automatic wait_idle(input int lim, input string tag);
      int n = 0;
      @(negedge clk);
      while (busy && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, busy, 0);
   endtask

   task automatic wait_red(input int val, input int lim, input string tag);
      int n = 0;
      while (dut.duty_q[2] != 4'(val) && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, dut.duty_q[2], val);
   endtask

   int n, hi, mx, prev, first, ticks, busy_bad, prev_pwm;
   logic [1:0] gb;

   initial begin
      // Reset held with all colours requested.
      repeat (2) @(negedge clk);
      chk("rst_out", rgb_out, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      chk("rst_no_ramp", {busy, dut.duty_q[2]}, 0);

      // Fade up red.
      rst = 1'b0;
      rgb_in = 3'b100;
      @(negedge clk);
      chk("up_busy", busy, 1);
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("up_ramp_len", n, 60);
      chk("up_duty", {dut.duty_q[2], dut.duty_q[1], dut.duty_q[0]}, 12'hf00);
      hi = 0; gb = 2'b00;
      repeat (16) begin
         @(negedge clk);
         hi += int'(rgb_out[2]);
         gb |= rgb_out[1:0];
      end
      chk("full_on_16", hi, 16);
      chk("gb_off", gb, 0);

      // Reversal at duty 7.
      rgb_in = 3'b000;
      wait_idle(200, "off_idle");
      rgb_in = 3'b100;
      @(negedge clk);
      wait_red(7, 100, "rev_reach7");
      chk("rev_busy_at7", busy, 1);
      rgb_in = 3'b000;
      mx = 7; prev = 7; first = -1; ticks = 0; busy_bad = 0; n = 0;
      while (dut.duty_q[2] != 0 && n < 200) begin
         @(negedge clk);
         n++;
         if (int'(dut.duty_q[2]) != prev) begin
            ticks++;
            if (first < 0) first = int'(dut.duty_q[2]);
            prev = int'(dut.duty_q[2]);
         end
         if (int'(dut.duty_q[2]) > mx) mx = int'(dut.duty_q[2]);
         if (!busy && dut.duty_q[2] != 0) busy_bad++;
      end
      chk("rev_first", first, 6);
      chk("rev_max", mx, 7);
      chk("rev_ticks", ticks, 7);
      chk("rev_busy_held", busy_bad, 0);
      chk("rev_idle", busy, 0);

      // Simultaneous ramp of all three.
      rgb_in = 3'b111;
      @(negedge clk);
      n = 0;
      while (busy && n < 200) begin
         chk("sim_lockstep", {dut.duty_q[1], dut.duty_q[0]}, {dut.duty_q[2], dut.duty_q[2]});
         @(negedge clk);
         n++;
      end
      chk("sim_all_full", {dut.duty_q[2], dut.duty_q[1], dut.duty_q[0]}, 12'hfff);
      rgb_in = 3'b010;
      @(negedge clk);
      n = 0;
      while (busy && n < 200) begin
         chk("sim_green_hold", dut.duty_q[1], 15);
         @(negedge clk);
         n++;
      end
      chk("sim_rb_off", {dut.duty_q[2], dut.duty_q[1], dut.duty_q[0]}, 12'h0f0);

      // Reset in the middle of a ramp.
      rgb_in = 3'b100;
      @(negedge clk);
      wait_red(9, 100, "mid_reach9");
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_clear", {rgb_out, busy, dut.duty_q[2], dut.duty_q[1], dut.duty_q[0]}, 0);
      repeat (3) @(negedge clk);
      chk("mid_rst_hold", {busy, dut.duty_q[2]}, 0);
      rst = 1'b0;
      rgb_in = 3'b000;
      repeat (3) @(negedge clk);

      // PWM shape at a held duty (slow instance).
      rst_s = 1'b0;
      rgb_in_s = 3'b100;
      n = 0;
      while (dut_s.duty_q[2] != 4'd5 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("slow_reach5", dut_s.duty_q[2], 5);
      @(negedge clk);
      hi = 0;
      prev_pwm = int'(dut_s.pwm_cnt_q);
      repeat (16) begin
         @(negedge clk);
         hi += int'(rgb_out_s[2]);
         chk("pwm_lag", rgb_out_s[2], (prev_pwm < eff_of(5)) ? 1 : 0);
         prev_pwm = int'(dut_s.pwm_cnt_q);
      end
      chk("pwm_5_of_16", hi, eff_of(5));
      chk("slow_busy", busy_s, 1);
`ifdef RGB_FADER_GAMMA_EN
      n = 0;
      while (dut_s.duty_q[2] != 4'd8 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      hi = 0;
      repeat (16) begin
         @(negedge clk);
         hi += int'(rgb_out_s[2]);
      end
      chk("gamma_8_of_16", hi, 4);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
